// File: rtl/dsp_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetches, hands the word to the decoder,
// then steps ALU, data memory and write-back, resolving branches at EXEC.
`ifndef INST_WORD_LEN
`define INST_WORD_LEN 32
`endif
`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif
`ifndef MEM_NONE
`define MEM_NONE   3'd0
`define MEM_LD     3'd1
`define MEM_ST     3'd2
`define MEM_LD_IMM 3'd3
`endif
`ifndef FLOW_NONE
`define FLOW_NONE 3'd0
`define FLOW_JMP  3'd1
`define FLOW_BEZ  3'd2
`define FLOW_BNEZ 3'd3
`define FLOW_BEQ  3'd4
`endif

// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_req held until imem_ack, opcode legality check
// DECODE | decoder settles, outputs sampled into shadows
// EXEC   | alu_en strobe, next pc resolved
// MEM    | data access with timeout down-counter
// WB     | rf_we strobe, pc and retired update
// HALT   | frozen until reset, err_code holds cause
module dsp_seq_ctrl #(
  parameter int PC_W   = 16,
  parameter int MEM_TO = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      imem_req,
  output logic [PC_W-1:0]           imem_addr,
  input  logic                      imem_ack,
  input  logic [`INST_WORD_LEN-1:0] imem_rdata,
  output logic [`INST_WORD_LEN-1:0] inst_out,
  input  logic [7:0]                alu_mode,
  input  logic                      r_w,
  input  logic [2:0]                mem_mode,
  input  logic [2:0]                flow_mode,
  input  logic [15:0]               data_s1,
  input  logic [15:0]               data_s2,
  input  logic [15:0]               beq_target,
  output logic                      alu_en,
  output logic                      dmem_req,
  output logic                      dmem_we,
  input  logic                      dmem_ack,
  output logic                      rf_we,
  output logic                      halted,
  output logic [1:0]                err_code,
  output logic [31:0]               retired
);

  localparam int TMR_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   npc;
  logic [PC_W-1:0]   branch_pc;
  logic [PC_W-1:0]   pc_inc;
  logic [TMR_W-1:0]  mem_tmr;
  logic              sh_r_w;
  logic [2:0]        sh_mem_mode;
  logic [2:0]        sh_flow_mode;
  logic [15:0]       sh_s1;
  logic [15:0]       sh_s2;
  logic [15:0]       sh_beq_target;
  logic              wb_we;
  logic [7:0]        fetch_op;

  assign imem_addr = pc;
  assign fetch_op  = imem_rdata[`INST_WORD_LEN-1 -: 8];
  assign pc_inc    = pc + 1'b1;
  assign wb_we     = sh_r_w || (sh_mem_mode == `MEM_LD) || (sh_mem_mode == `MEM_LD_IMM);

  function automatic logic op_legal(input logic [7:0] op);
    op_legal = (op <= 8'h0D) ||
               (op >= 8'h10 && op <= 8'h1B) ||
               (op >= 8'h20 && op <= 8'h23) ||
               (op >= 8'h32 && op <= 8'h34);
  endfunction

  always_comb begin
    branch_pc = pc_inc;
    case (sh_flow_mode)
      `FLOW_JMP:  branch_pc = PC_W'(sh_s2);
      `FLOW_BEZ:  if (sh_s1 == 16'd0) branch_pc = PC_W'(sh_s2);
      `FLOW_BNEZ: if (sh_s1 != 16'd0) branch_pc = PC_W'(sh_s2);
      `FLOW_BEQ:  if (sh_s1 == sh_s2) branch_pc = PC_W'(sh_beq_target);
      default:    branch_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      npc           <= '0;
      inst_out      <= '0;
      retired       <= '0;
      err_code      <= 2'd0;
      halted        <= 1'b0;
      imem_req      <= 1'b0;
      alu_en        <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      rf_we         <= 1'b0;
      mem_tmr       <= '0;
      sh_r_w        <= 1'b0;
      sh_mem_mode   <= `MEM_NONE;
      sh_flow_mode  <= `FLOW_NONE;
      sh_s1         <= '0;
      sh_s2         <= '0;
      sh_beq_target <= '0;
    end else begin
      alu_en <= 1'b0;
      rf_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            // an illegal word never reaches the decoder
            if (op_legal(fetch_op)) begin
              inst_out <= imem_rdata;
              state    <= S_DECODE;
            end else begin
              err_code <= 2'd1;
              halted   <= 1'b1;
              state    <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          sh_r_w        <= r_w;
          sh_mem_mode   <= mem_mode;
          sh_flow_mode  <= flow_mode;
          sh_s1         <= data_s1;
          sh_s2         <= data_s2;
          sh_beq_target <= beq_target;
          alu_en        <= (alu_mode != `ALU_NOP);
          state         <= S_EXEC;
        end
        S_EXEC: begin
          npc <= branch_pc;
          if (sh_mem_mode != `MEM_NONE) begin
            dmem_req <= 1'b1;
            dmem_we  <= (sh_mem_mode == `MEM_ST);
            mem_tmr  <= TMR_W'(MEM_TO - 1);
            state    <= S_MEM;
          end else begin
            rf_we <= wb_we;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= wb_we;
            state    <= S_WB;
          end else if (mem_tmr == '0) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            err_code <= 2'd2;
            halted   <= 1'b1;
            state    <= S_HALT;
          end else begin
            mem_tmr <= mem_tmr - 1'b1;
          end
        end
        S_WB: begin
          pc       <= npc;
          retired  <= retired + 32'd1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
